operand_fetch_ctrl: RTL and testbench
=====================================

OPERAND_FETCH_CTRL -- requirements
Module: operand_fetch_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning the operand and register-file data width.
REQ-002 The block SHALL have parameter ADDR_W, default 3, meaning the register-file address width (8 registers).
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1, meaning a request to fetch operands, sampled only in IDLE.
REQ-006 The block SHALL have port rs_a, input, ADDR_W, meaning the source register for operand A, latched with start.
REQ-007 The block SHALL have port rs_b, input, ADDR_W, meaning the source register for operand B, latched with start.
REQ-008 The block SHALL have port need_b, input, 1, meaning the instruction uses operand B, latched with start.
REQ-009 The block SHALL have port wb_active, input, 1, meaning writeback owns the shared register-file port this cycle.
REQ-010 The block SHALL have port flush, input, 1, meaning a synchronous abort of the current fetch.
REQ-011 The block SHALL have port rf_rdata, input, DATA_W, meaning register-file read data, valid one cycle after rf_rd_en.
REQ-012 The block SHALL have port rf_rd_en, output, 1, meaning the read strobe to the shared register-file port.
REQ-013 The block SHALL have port rf_addr, output, ADDR_W, meaning the read address, valid while rf_rd_en=1.
REQ-014 The block SHALL have port opa, output, DATA_W, meaning the registered operand A.
REQ-015 The block SHALL have port opb, output, DATA_W, meaning the registered operand B.
REQ-016 The block SHALL have port busy, output, 1, meaning a fetch is in progress (any state but IDLE).
REQ-017 The block SHALL have port done, output, 1, meaning a one-cycle pulse indicating opa/opb are valid.
REQ-018 The block SHALL have port stall_cnt, output, 8, meaning the count of wb_active stall cycles in the current/last fetch.

Function
REQ-019 The FSM SHALL have states IDLE, REQ_A, CAP_A, REQ_B, CAP_B, DONE.
REQ-020 IDLE: on start=1, the block SHALL latch rs_a, rs_b, need_b, clear stall_cnt to 0, and go to REQ_A; otherwise stay.
REQ-021 REQ_A/REQ_B with wb_active=0: rf_rd_en=1, rf_addr=latched rs_a/rs_b (combinational), next CAP_A/CAP_B.
REQ-022 REQ_A/REQ_B with wb_active=1: rf_rd_en=0, the state SHALL hold, and stall_cnt SHALL increment, saturating at 255.
REQ-023 In all states other than a non-stalled REQ_A/REQ_B, rf_rd_en SHALL be 0 and rf_addr SHALL be 0.
REQ-024 CAP_A: opa <= rf_rdata; next REQ_B if latched need_b=1, else opb <= 0 and next DONE.
REQ-025 CAP_B: opb <= rf_rdata; next DONE.
REQ-026 DONE: done=1 for exactly this cycle; next IDLE unconditionally.
REQ-027 busy SHALL be 1 in every state except IDLE, including DONE.
REQ-028 start SHALL be ignored while busy=1; a start in the cycle IDLE is re-entered after DONE SHALL be accepted.
REQ-029 Latency with no stalls: done asserts 3 cycles after the start edge (need_b=0) or 5 cycles (need_b=1); each stall cycle adds 1.
REQ-030 flush=1 in any non-IDLE state SHALL force IDLE next edge without done, with opa/opb unchanged; flush has priority over all transitions.
REQ-031 flush=1 in IDLE together with start=1 SHALL suppress start.
REQ-032 A rf_rdata capture SHALL occur only in CAP_A/CAP_B; rf_rdata is ignored elsewhere.

Reset
REQ-033 rst_n=0 SHALL immediately force state IDLE, opa=0, opb=0, stall_cnt=0, latched rs_a/rs_b/need_b=0, busy=0, done=0, rf_rd_en=0.
REQ-034 Reset asserted mid-fetch SHALL abandon the fetch with no done pulse; operation resumes from IDLE on the first edge after rst_n=1.

Verification
REQ-035 Bench: start, rs_a=2, rs_b=5, need_b=1, R2=16'h1234, R5=16'hABCD, wb_active=0 -> reads addr 2 then 5, done 5 cycles after start, opa=1234, opb=ABCD, stall_cnt=0.
REQ-036 Bench: start, rs_a=7, need_b=0, R7=16'h00FF -> single read, done 3 cycles after start, opa=00FF, opb=0000.
REQ-037 Bench: need_b=1, wb_active=1 for 2 cycles in REQ_A and 1 in REQ_B -> rf_rd_en low during stalls, done 8 cycles after start, stall_cnt=3.
REQ-038 Bench: flush in CAP_A after a prior fetch left opa=1234 -> IDLE next edge, no done, opb unchanged, next start accepted normally.
REQ-039 Bench: start held high continuously -> back-to-back fetches, one done per fetch, starts during busy ignored.
REQ-040 Bench: rst_n pulsed low in REQ_B -> outputs zero immediately, no done; wb_active held 300 cycles in REQ_A -> stall_cnt saturates at 255.

Source files
------------

// File: rtl/operand_fetch_ctrl.sv
// Operand fetch sequencer: reads up to two source registers through a register-file
// port shared with writeback, stalling while writeback owns the port.
module operand_fetch_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] rs_a,
  input  logic [ADDR_W-1:0] rs_b,
  input  logic              need_b,
  input  logic              wb_active,
  input  logic              flush,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              rf_rd_en,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] opa,
  output logic [DATA_W-1:0] opb,
  output logic              busy,
  output logic              done,
  output logic [7:0]        stall_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ_A = 3'd1,
    CAP_A = 3'd2,
    REQ_B = 3'd3,
    CAP_B = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] rs_a_q;
  logic [ADDR_W-1:0] rs_b_q;
  logic              need_b_q;
  logic              stalled;

  // NOTE: every output of this block gets a default first, so no path through the
  // case statement leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    rf_rd_en = 1'b0;
    rf_addr  = '0;
    stalled  = 1'b0;
    case (state)
      IDLE:  if (start) state_nx = REQ_A;
      REQ_A: begin
        if (wb_active) begin
          stalled = 1'b1;
        end else begin
          rf_rd_en = 1'b1;
          rf_addr  = rs_a_q;
          state_nx = CAP_A;
        end
      end
      CAP_A: state_nx = need_b_q ? REQ_B : DONE;
      REQ_B: begin
        if (wb_active) begin
          stalled = 1'b1;
        end else begin
          rf_rd_en = 1'b1;
          rf_addr  = rs_b_q;
          state_nx = CAP_B;
        end
      end
      CAP_B:   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // Flush overrides every transition, and in IDLE it also swallows a start.
    if (flush) state_nx = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_a_q    <= '0;
      rs_b_q    <= '0;
      need_b_q  <= 1'b0;
      opa       <= '0;
      opb       <= '0;
      stall_cnt <= '0;
    end else if (!flush) begin
      if (state == IDLE && start) begin
        rs_a_q    <= rs_a;
        rs_b_q    <= rs_b;
        need_b_q  <= need_b;
        stall_cnt <= '0;
      end
      if (stalled && stall_cnt != 8'hFF) stall_cnt <= stall_cnt + 8'd1;
      if (state == CAP_A) begin
        opa <= rf_rdata;
        if (!need_b_q) opb <= '0;
      end
      if (state == CAP_B) opb <= rf_rdata;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_operand_fetch_ctrl.sv
// Self-checking bench for operand_fetch_ctrl: directed table, randomized fetches
// against a read-schedule model, and hand sequences for flush, reset and saturation.
module tb_operand_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  rs_a;
  logic [2:0]  rs_b;
  logic        need_b;
  logic        wb_active;
  logic        flush;
  logic [15:0] rf_rdata;
  logic        rf_rd_en;
  logic [2:0]  rf_addr;
  logic [15:0] opa;
  logic [15:0] opb;
  logic        busy;
  logic        done;
  logic [7:0]  stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] regs [8];

  operand_fetch_ctrl #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .rs_a      (rs_a),
    .rs_b      (rs_b),
    .need_b    (need_b),
    .wb_active (wb_active),
    .flush     (flush),
    .rf_rdata  (rf_rdata),
    .rf_rd_en  (rf_rd_en),
    .rf_addr   (rf_addr),
    .opa       (opa),
    .opb       (opb),
    .busy      (busy),
    .done      (done),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  // Register file: data one cycle after the strobe, garbage whenever not read.
  always @(posedge clk) begin
    if (rf_rd_en) rf_rdata <= regs[rf_addr];
    else          rf_rdata <= 16'($urandom);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic wb_at(input logic [31:0] wbm, input int t);
    return (t < 32) ? wbm[t] : 1'b0;
  endfunction

  // Each read waits for the first cycle without writeback, then takes two cycles
  // (strobe + capture); done lands in the cycle after the last capture.
  function automatic int model_done(input logic nb, input logic [31:0] wbm, output int stalls);
    int t = 1;
    stalls = 0;
    for (int r = 0; r < (nb ? 2 : 1); r++) begin
      while (wb_at(wbm, t)) begin
        stalls++;
        t++;
      end
      t += 2;
    end
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one fetch from IDLE; wbm bit t is wb_active during cycle t after the start edge.
  task automatic run_fetch(input logic [2:0] ra, input logic [2:0] rb, input logic nb,
                           input logic [31:0] wbm, input int exp_done,
                           input logic [15:0] exp_opa, input logic [15:0] exp_opb,
                           input logic [7:0] exp_stall, input string name);
    bit          grant [401];
    logic [2:0]  gaddr [401];
    int          t = 1;
    int          obs_done = -1;
    for (int i = 0; i <= 400; i++) begin
      grant[i] = 1'b0;
      gaddr[i] = 3'd0;
    end
    for (int r = 0; r < (nb ? 2 : 1); r++) begin
      while (wb_at(wbm, t)) t++;
      grant[t] = 1'b1;
      gaddr[t] = (r == 0) ? ra : rb;
      t += 2;
    end
    start = 1'b1; rs_a = ra; rs_b = rb; need_b = nb; wb_active = 1'b0;
    tick();
    start = 1'b0; rs_a = 3'($urandom); rs_b = 3'($urandom); need_b = 1'($urandom);
    for (int c = 1; c <= 400 && obs_done < 0; c++) begin
      wb_active = wb_at(wbm, c);
      #1;
      check({name, " rd_en"}, 32'(rf_rd_en), 32'(grant[c]));
      check({name, " addr"}, 32'(rf_addr), 32'(gaddr[c]));
      check({name, " busy"}, 32'(busy), 32'd1);
      if (done) obs_done = c;
      else tick();
    end
    check({name, " done cycle"}, 32'(obs_done), 32'(exp_done));
    check({name, " opa"}, 32'(opa), 32'(exp_opa));
    check({name, " opb"}, 32'(opb), 32'(exp_opb));
    check({name, " stall_cnt"}, 32'(stall_cnt), 32'(exp_stall));
    tick();
    wb_active = 1'b0;
    check({name, " idle busy"}, 32'(busy), 32'd0);
    check({name, " idle done"}, 32'(done), 32'd0);
  endtask

  typedef struct {
    string       name;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic        nb;
    logic [31:0] wbm;
    int          exp_done;
    logic [15:0] exp_opa;
    logic [15:0] exp_opb;
    logic [7:0]  exp_stall;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int stalls;
    int md;
    int n_done;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic        nb;
    logic [31:0] wbm;

    regs[0] = 16'h0F0F; regs[1] = 16'h1111; regs[2] = 16'h1234; regs[3] = 16'h3C3C;
    regs[4] = 16'h8001; regs[5] = 16'hABCD; regs[6] = 16'h6666; regs[7] = 16'h00FF;

    vecs[0] = '{"two_op",    3'd2, 3'd5, 1'b1, 32'h0,  5, 16'h1234, 16'hABCD, 8'd0};
    vecs[1] = '{"one_op",    3'd7, 3'd3, 1'b0, 32'h0,  3, 16'h00FF, 16'h0000, 8'd0};
    vecs[2] = '{"stalled",   3'd7, 3'd2, 1'b1, 32'h26, 8, 16'h00FF, 16'h1234, 8'd3};
    vecs[3] = '{"one_stall", 3'd4, 3'd0, 1'b0, 32'h6,  5, 16'h8001, 16'h0000, 8'd2};

    rst_n = 1'b0; start = 1'b0; rs_a = 3'd0; rs_b = 3'd0; need_b = 1'b0;
    wb_active = 1'b0; flush = 1'b0;
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset rd_en", 32'(rf_rd_en), 32'd0);
    check("reset opa", 32'(opa), 32'd0);
    check("reset opb", 32'(opb), 32'd0);
    check("reset stall", 32'(stall_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    foreach (vecs[i])
      run_fetch(vecs[i].ra, vecs[i].rb, vecs[i].nb, vecs[i].wbm, vecs[i].exp_done,
                vecs[i].exp_opa, vecs[i].exp_opb, vecs[i].exp_stall, vecs[i].name);

    for (int i = 0; i < 30; i++) begin
      ra  = 3'($urandom);
      rb  = 3'($urandom);
      nb  = 1'($urandom);
      wbm = $urandom & $urandom;
      md  = model_done(nb, wbm, stalls);
      run_fetch(ra, rb, nb, wbm, md, regs[ra], nb ? regs[rb] : 16'h0, 8'(stalls), "random");
    end

    // Flush in CAP_A after a fetch left opa=1234/opb=ABCD.
    run_fetch(3'd2, 3'd5, 1'b1, 32'h0, 5, 16'h1234, 16'hABCD, 8'd0, "pre_flush");
    start = 1'b1; rs_a = 3'd7; rs_b = 3'd0; need_b = 1'b0;
    tick();
    start = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush busy", 32'(busy), 32'd0);
    check("flush done", 32'(done), 32'd0);
    check("flush opa", 32'(opa), 32'h1234);
    check("flush opb", 32'(opb), 32'hABCD);
    run_fetch(3'd7, 3'd1, 1'b0, 32'h0, 3, 16'h00FF, 16'h0000, 8'd0, "post_flush");

    start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    check("flush_start busy", 32'(busy), 32'd0);

    // Start held high: one fetch every four cycles, with starts during busy ignored.
    start = 1'b1; rs_a = 3'd1; need_b = 1'b0;
    tick();
    n_done = 0;
    for (int c = 1; c <= 20; c++) begin
      if (done) begin
        n_done++;
        check("b2b done phase", 32'(c % 4), 32'd3);
      end
      tick();
    end
    check("b2b done count", 32'(n_done), 32'd5);
    start = 1'b0;
    for (int c = 0; c < 8 && busy; c++) tick();
    check("b2b idle", 32'(busy), 32'd0);

    // Reset while in REQ_B.
    run_fetch(3'd6, 3'd3, 1'b1, 32'h0, 5, 16'h6666, 16'h3C3C, 8'd0, "pre_reset");
    start = 1'b1; rs_a = 3'd2; rs_b = 3'd5; need_b = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("reqb rd_en", 32'(rf_rd_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset rd_en", 32'(rf_rd_en), 32'd0);
    check("midreset done", 32'(done), 32'd0);
    check("midreset opa", 32'(opa), 32'd0);
    check("midreset opb", 32'(opb), 32'd0);
    tick();
    #2;
    rst_n = 1'b1;
    tick();
    check("postreset done", 32'(done), 32'd0);
    run_fetch(3'd5, 3'd2, 1'b1, 32'h0, 5, 16'hABCD, 16'h1234, 8'd0, "post_reset");

    // 300 stall cycles in REQ_A saturate the counter.
    start = 1'b1; rs_a = 3'd3; need_b = 1'b0;
    tick();
    start = 1'b0; wb_active = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      if (c == 101) check("sat stall 100", 32'(stall_cnt), 32'd100);
      if (c == 150) check("sat rd_en", 32'(rf_rd_en), 32'd0);
      tick();
    end
    check("sat stall 255", 32'(stall_cnt), 32'd255);
    check("sat busy", 32'(busy), 32'd1);
    wb_active = 1'b0;
    for (int c = 0; c < 10 && !done; c++) tick();
    check("sat done", 32'(done), 32'd1);
    check("sat opa", 32'(opa), 32'h3C3C);
    check("sat final stall", 32'(stall_cnt), 32'd255);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
